// File: rtl/pico_pkg.sv
// Shared state encoding, data width and default timing for the pico I/O host.
package pico_pkg;

   localparam int WORD_W             = 8;
   localparam int CNT_W              = 8;
   localparam int TMO_W              = 16;
   localparam int DEF_HOLD_CYCLES    = 4;
   localparam int DEF_SETTLE_CYCLES  = 3;
   localparam int DEF_TIMEOUT_CYCLES = 64;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE_X,
      DRIVE_Y,
      WAIT_LED,
      RESULT
   } host_state_t;

endpackage

// File: rtl/pico_cycle_timer.sv
// Loadable down-counter that saturates at zero; done_o is high while the count is zero.
// Loading N and enabling every cycle raises done_o after N enabled cycles.
module pico_cycle_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         done_o
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pico_io_host.sv
// Host side of a switch/LED processor link: drives x then y on the switch bus, waits for a settled LED result.
// Accept-to-result at least 2*HOLD+SETTLE+2 cycles; result held until res_ready_i. PICO_HOST_TIMEOUT_EN adds a WAIT_LED timeout.
module pico_io_host
   import pico_pkg::*;
#(
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   input  logic [WORD_W-1:0] in_x_i,
   input  logic [WORD_W-1:0] in_y_i,
   output logic              in_ready_o,
   output logic [WORD_W-1:0] sw_data_o,
   output logic              sw_hold_o,
   input  logic [WORD_W-1:0] led_in_i,
   output logic              res_valid_o,
   output logic [WORD_W-1:0] res_data_o,
`ifdef PICO_HOST_TIMEOUT_EN
   output logic              res_timeout_o,
`endif
   input  logic              res_ready_i
);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("HOLD_CYCLES out of range 1..255");
   end
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("SETTLE_CYCLES out of range 1..255");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 2..65535");
   end

   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

   host_state_t       state_q, state_d;
   logic [WORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [WORD_W-1:0] ref_q, ref_d;
   logic [WORD_W-1:0] res_q, res_d;
   logic              chg_q, chg_d;
   logic              ready_q;
   logic              accept;
   logic              tmr_load, tmr_en, tmr_done;
   logic [CNT_W-1:0]  tmr_val;

   // One timer serves both the hold phases and the LED settle window; they never overlap.
   pico_cycle_timer #(.W(CNT_W)) u_hold_settle (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .done_o     (tmr_done)
   );

`ifdef PICO_HOST_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LD = TMO_W'(TIMEOUT_CYCLES - 1);

   logic to_load, to_en, to_done;
   logic tmo_q, tmo_d;

   pico_cycle_timer #(.W(TMO_W)) u_timeout (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (to_load),
      .load_val_i (TMO_LD),
      .en_i       (to_en),
      .done_o     (to_done)
   );

   assign res_timeout_o = tmo_q;
`endif

   assign accept = in_valid_i && in_ready_o;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      ref_d    = ref_q;
      chg_d    = chg_q;
      res_d    = res_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = HOLD_LD;
`ifdef PICO_HOST_TIMEOUT_EN
      to_load  = 1'b0;
      to_en    = 1'b0;
      tmo_d    = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               x_d      = in_x_i;
               y_d      = in_y_i;
               tmr_load = 1'b1;
               state_d  = DRIVE_X;
`ifdef PICO_HOST_TIMEOUT_EN
               tmo_d    = 1'b0;
`endif
            end
         end
         DRIVE_X: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               state_d  = DRIVE_Y;
            end else begin
               tmr_en = 1'b1;
            end
         end
         DRIVE_Y: begin
            if (tmr_done) begin
               ref_d   = led_in_i;
               chg_d   = 1'b0;
               state_d = WAIT_LED;
`ifdef PICO_HOST_TIMEOUT_EN
               to_load = 1'b1;
`endif
            end else begin
               tmr_en = 1'b1;
            end
         end
         WAIT_LED: begin
            tmr_val = SETTLE_LD;
            // ref_q is the entry snapshot until the first change, then the value being settled on.
            if (led_in_i != ref_q) begin
               chg_d    = 1'b1;
               ref_d    = led_in_i;
               tmr_load = 1'b1;
            end else if (chg_q && tmr_done) begin
               res_d   = led_in_i;
               state_d = RESULT;
            end else if (chg_q) begin
               tmr_en = 1'b1;
            end
`ifdef PICO_HOST_TIMEOUT_EN
            if (state_d == WAIT_LED) begin
               if (to_done) begin
                  res_d   = led_in_i;
                  tmo_d   = 1'b1;
                  state_d = RESULT;
               end else begin
                  to_en = 1'b1;
               end
            end
`endif
         end
         RESULT: begin
            if (res_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         ref_q   <= '0;
         chg_q   <= 1'b0;
         res_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ref_q   <= ref_d;
         chg_q   <= chg_d;
         res_q   <= res_d;
         ready_q <= 1'b1;
      end
   end

`ifdef PICO_HOST_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   always_comb begin
      sw_data_o = '0;
      case (state_q)
         IDLE:    sw_data_o = '0;
         DRIVE_X: sw_data_o = x_q;
         default: sw_data_o = y_q;
      endcase
   end

   assign in_ready_o  = ready_q && (state_q == IDLE);
   assign sw_hold_o   = (state_q == DRIVE_X);
   assign res_valid_o = (state_q == RESULT);
   assign res_data_o  = res_q;

endmodule

// File: tb/tb_pico_io_host.sv
// Directed bench for pico_io_host with HOLD=4, SETTLE=3, TIMEOUT=64.
`timescale 1ns/1ps
module tb_pico_io_host;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       res_ready = 1'b0;
   logic [7:0] in_x = 8'h00;
   logic [7:0] in_y = 8'h00;
   logic [7:0] led = 8'h00;
   logic       in_ready, sw_hold, res_valid;
   logic [7:0] sw_data, res_data;
`ifdef PICO_HOST_TIMEOUT_EN
   logic       res_timeout;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pico_io_host #(
      .HOLD_CYCLES    (4),
      .SETTLE_CYCLES  (3),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .in_valid_i    (in_valid),
      .in_x_i        (in_x),
      .in_y_i        (in_y),
      .in_ready_o    (in_ready),
      .sw_data_o     (sw_data),
      .sw_hold_o     (sw_hold),
      .led_in_i      (led),
      .res_valid_o   (res_valid),
      .res_data_o    (res_data),
`ifdef PICO_HOST_TIMEOUT_EN
      .res_timeout_o (res_timeout),
`endif
      .res_ready_i   (res_ready)
   );

   // pre: WAIT_LED cycles before the LED changes; exp_lat: edges from accept to res_valid.
   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] led;
      int         pre;
      logic [7:0] exp_res;
      int         exp_lat;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_txn(input logic [7:0] x, input logic [7:0] y);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_x     = x;
      in_y     = y;
      tick();
      in_valid = 1'b0;
      in_x     = 8'($urandom);
      in_y     = 8'($urandom);
   endtask

   task automatic consume();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("res_drop", 32'(res_valid), 32'd0);
      check("back_idle", 32'(in_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      start_txn(v.x, v.y);
      lat = 0;
      for (int i = 0; i < 4; i++) begin
         check("drive_x", 32'({sw_hold, sw_data}), 32'({1'b1, v.x}));
         tick();
         lat++;
      end
      for (int i = 0; i < 4; i++) begin
         check("drive_y", 32'({sw_hold, sw_data}), 32'({1'b0, v.y}));
         tick();
         lat++;
      end
      check("wait_busy", 32'({in_ready, sw_hold, sw_data}), 32'({2'b00, v.y}));
      for (int k = 0; k < v.pre; k++) begin
         check("wait_no_res", 32'(res_valid), 32'd0);
         tick();
         lat++;
      end
      led = v.led;
      while (res_valid !== 1'b1 && lat < 200) begin
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'(v.exp_lat));
      check("res_data", 32'(res_data), 32'(v.exp_res));
      consume();
   endtask

   initial begin
      int n;
      vecs[0] = '{8'h12, 8'h34, 8'h5A, 2, 8'h5A, 15};
      vecs[1] = '{8'hFF, 8'h00, 8'hA5, 0, 8'hA5, 13};
      vecs[2] = '{8'h00, 8'hFF, 8'h01, 1, 8'h01, 14};
      vecs[3] = '{8'h80, 8'h7F, 8'h00, 3, 8'h00, 16};
      vecs[4] = '{8'h12, 8'h34, 8'h0F, 0, 8'h0F, 13};

      #1 rst_n = 1'b0;
      #2;
      check("rst_outputs", 32'({sw_hold, res_valid, in_ready, sw_data, res_data}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 32'(in_ready), 32'd0);
      tick();
      check("ready_after_edge", 32'(in_ready), 32'd1);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // LED glitches during settle, then result held against a blocked consumer.
      start_txn(8'hC3, 8'h3C);
      repeat (8) tick();
      check("glitch_wait", 32'({sw_hold, sw_data}), 32'({1'b0, 8'h3C}));
      led = 8'h5A;
      tick();
      led = 8'h5B;
      tick();
      check("glitch_no_res", 32'(res_valid), 32'd0);
      led = 8'h5A;
      tick();
      n = 0;
      while (res_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("glitch_lat", 32'(11 + n), 32'd15);
      check("glitch_data", 32'(res_data), 32'h5A);
      in_valid = 1'b1;
      in_x     = 8'hAA;
      in_y     = 8'hBB;
      for (int i = 0; i < 10; i++) begin
         check("hold_result", 32'({res_valid, in_ready, res_data}), 32'({2'b10, 8'h5A}));
         tick();
      end
      in_valid = 1'b0;
      consume();
      tick();
      check("no_second_accept", 32'({sw_hold, res_valid}), 32'd0);

      // Reset mid DRIVE_Y.
      start_txn(8'h11, 8'h22);
      repeat (6) tick();
      check("pre_rst_drive_y", 32'({sw_hold, sw_data}), 32'({1'b0, 8'h22}));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst", 32'({sw_hold, res_valid, in_ready, sw_data, res_data}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_release_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 20; i++) begin
         check("rst_no_result", 32'({res_valid, sw_hold}), 32'd0);
         tick();
      end

      run_vec(vecs[4]);

`ifdef PICO_HOST_TIMEOUT_EN
      start_txn(8'h44, 8'h55);
      n = 0;
      while (res_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("timeout_lat", 32'(n), 32'd72);
      check("timeout_flag", 32'(res_timeout), 32'd1);
      check("timeout_data", 32'(res_data), 32'h0F);
      consume();
      start_txn(8'h66, 8'h77);
      check("timeout_clear", 32'(res_timeout), 32'd0);
      led = 8'h33;
      n = 0;
      while (res_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("post_timeout_data", 32'({res_timeout, res_data}), 32'({1'b0, 8'h33}));
      consume();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pico_io_host.md
PICO_IO_HOST -- requirements
Module: pico_io_host

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4: cycles each operand is held on the switch bus (range 1..255).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 3: consecutive cycles LED must be unchanged before capture (range 1..255).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT_LED duration when the timeout feature is compiled in (range 2..65535).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  host offers an operand pair.
REQ-007 in_x  input  8  first operand.
REQ-008 in_y  input  8  second operand.
REQ-009 in_ready  output  1  block accepts a pair; high only in IDLE.
REQ-010 sw_data  output  8  drives processor switch inputs SW[7:0].
REQ-011 sw_hold  output  1  drives processor SW[8] handshake line.
REQ-012 led_in  input  8  processor LED result bus.
REQ-013 res_valid  output  1  result available.
REQ-014 res_data  output  8  captured LED value.
REQ-015 res_ready  input  1  host consumes the result.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE_X, DRIVE_Y, WAIT_LED and RESULT.
REQ-017 IDLE: in_valid && in_ready accepts; x/y registered; next state DRIVE_X.
REQ-018 DRIVE_X: sw_data=x and sw_hold=1 for exactly HOLD_CYCLES cycles; then DRIVE_Y.
REQ-019 DRIVE_Y: sw_data=y and sw_hold=0 for exactly HOLD_CYCLES cycles; then WAIT_LED.
REQ-020 WAIT_LED entry: led_in is snapshotted; sw_data stays y and sw_hold stays 0.
REQ-021 WAIT_LED: the block waits for led_in to differ from the snapshot, then for led_in to stay equal for SETTLE_CYCLES consecutive cycles; any change restarts the settle count.
REQ-022 On settle complete, res_data SHALL take the current led_in and the FSM SHALL go to RESULT.
REQ-023 RESULT: res_valid=1 and res_data stable until res_ready; a transfer returns the FSM to IDLE next cycle.
REQ-024 There SHALL be no bypass: min latency from accept to res_valid is 2*HOLD_CYCLES+SETTLE_CYCLES+2 cycles.
REQ-025 in_valid while not IDLE SHALL be ignored; in_x/in_y may change freely outside the accept cycle.
REQ-026 The counters SHALL saturate, never wrap; an 8-bit hold/settle counter and a 16-bit timeout counter.

Reset
REQ-027 On reset low, the FSM SHALL enter IDLE immediately, including mid-transaction.
REQ-028 While reset is low, sw_data=0, sw_hold=0, res_valid=0, res_data=0 and counters clear; in_ready=1 from the first edge after release.

Configuration
REQ-029 With PICO_HOST_TIMEOUT_EN defined, output res_timeout (1 bit) SHALL exist; if WAIT_LED lasts TIMEOUT_CYCLES, res_data=led_in, res_timeout=1 and the FSM goes to RESULT; res_timeout clears on the next accept.
REQ-030 Without PICO_HOST_TIMEOUT_EN, the res_timeout port and the timeout counter SHALL be absent and WAIT_LED SHALL wait indefinitely; a result equal to the previous LED value then hangs until reset.

Structure
REQ-031 Package pico_pkg SHALL hold the state enum (host_state_t), WORD_W=8 and the default timing constants.
REQ-032 One sub-module, pico_cycle_timer (load, enable, saturating count, done flag), SHALL implement the hold, settle and timeout counts.

Verification (HOLD_CYCLES=4, SETTLE_CYCLES=3, TIMEOUT_CYCLES=64)
REQ-033 Pair x=8'h12, y=8'h34 -> sw_hold=1 with sw_data=12 for 4 cycles, then sw_hold=0 with sw_data=34 for 4 cycles.
REQ-034 LED model changes 00->5A 2 cycles into WAIT_LED -> res_valid=1 with res_data=5A, 3 cycles after the change (+1 register).
REQ-035 LED glitches 5A->5B->5A during settle -> settle restarts and final res_data equals the last stable value.
REQ-036 res_ready held low for 10 cycles -> res_valid and res_data stable; in_ready=0 throughout; second pair not accepted.
REQ-037 Reset pulsed mid DRIVE_Y -> sw_data=0 and sw_hold=0 asynchronously, in_ready=1 after release, no res_valid.
REQ-038 With the macro defined, LED never changes -> after 64 WAIT_LED cycles res_valid=1, res_timeout=1 and res_data=snapshot.
